// File: rtl/alu_issue_if.sv
`default_nettype none
// ============================================================================
// alu_issue_if : request / ALU / response bundle for alu_issue_unit
// Revision 1.0
// ============================================================================
interface alu_issue_if;
    // request side
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_dir;
    logic        req_use_carry;
    // towards the combinational ALU
    logic [31:0] alu_reg1;
    logic [31:0] alu_reg2;
    logic [2:0]  alu_op;
    logic        alu_cin;
    logic        alu_dir;
    // back from the ALU
    logic [31:0] alu_res;
    logic        alu_carry;
    logic        alu_zero;
    logic        alu_neg;
    logic        alu_upd_carry;
    // response and architectural state
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_res;
    logic        flag_c;
    logic        flag_z;
    logic        flag_n;
    logic        flag_clear;
    logic [15:0] op_count;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_dir, req_use_carry,
        output req_ready,
        output alu_reg1, alu_reg2, alu_op, alu_cin, alu_dir,
        input  alu_res, alu_carry, alu_zero, alu_neg, alu_upd_carry,
        output rsp_valid, rsp_res,
        input  rsp_ready,
        output flag_c, flag_z, flag_n, op_count,
        input  flag_clear
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_dir, req_use_carry,
        input  req_ready,
        input  alu_reg1, alu_reg2, alu_op, alu_cin, alu_dir,
        output alu_res, alu_carry, alu_zero, alu_neg, alu_upd_carry,
        input  rsp_valid, rsp_res,
        output rsp_ready,
        input  flag_c, flag_z, flag_n, op_count,
        output flag_clear
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_unit.sv
`default_nettype none
// ============================================================================
// alu_issue_unit : issues one operation to an external ALU, captures result
//                  and flags, and returns them over a valid/ready response.
// Revision 1.0
// ============================================================================
module alu_issue_unit (
    input  wire logic  clk,
    input  wire logic  rst,
    alu_issue_if.slave bus
);
    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        req_ready;
    logic        rsp_valid;
    logic        accept;
    logic        rsp_done;

    logic [31:0] alu_reg1;
    logic [31:0] alu_reg2;
    logic [2:0]  alu_op;
    logic        alu_cin;
    logic        alu_dir;
    logic [31:0] rsp_res;
    logic        flag_c;
    logic        flag_z;
    logic        flag_n;
    logic [15:0] op_count;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // ALU operand registers: loaded only on accept, so they stay stable
    // for the whole operation and the carry-in is frozen at accept time.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_reg1 <= '0;
            alu_reg2 <= '0;
            alu_op   <= '0;
            alu_cin  <= 1'b0;
            alu_dir  <= 1'b0;
        end else if (accept) begin
            alu_reg1 <= bus.req_a;
            alu_reg2 <= bus.req_b;
            alu_op   <= bus.req_op;
            alu_cin  <= bus.req_use_carry & flag_c;
            alu_dir  <= bus.req_dir;
        end
    end

    // ------------------------------------------------------------------
    // Result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_res <= '0;
        end else if (state == CAPTURE) begin
            rsp_res <= bus.alu_res;
        end
    end

    // A capture beats a simultaneous clear for Z/N; for C a clear only
    // lands when the ALU is not updating the carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (state == CAPTURE) begin
            flag_z <= bus.alu_zero;
            flag_n <= bus.alu_neg;
            if (bus.alu_upd_carry) begin
                flag_c <= bus.alu_carry;
            end else if (bus.flag_clear) begin
                flag_c <= 1'b0;
            end
        end else if (bus.flag_clear) begin
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Completed-response counter, saturating
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (rsp_done && (op_count != COUNT_MAX)) begin
            op_count <= op_count + 16'd1;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_res   = rsp_res;
    assign bus.alu_reg1  = alu_reg1;
    assign bus.alu_reg2  = alu_reg2;
    assign bus.alu_op    = alu_op;
    assign bus.alu_cin   = alu_cin;
    assign bus.alu_dir   = alu_dir;
    assign bus.flag_c    = flag_c;
    assign bus.flag_z    = flag_z;
    assign bus.flag_n    = flag_n;
    assign bus.op_count  = op_count;

endmodule
`default_nettype wire
